// File: rtl/adc_seq_sched.sv
// Multi-channel ADC sequencer: converts enabled channels on each trigger
// edge into a shadow bank, then publishes the bank at the valley update.
module adc_seq_sched #(
   parameter int NCH    = 4,
   parameter int CHW    = 2,
   parameter int DW     = 12,
   parameter int TO_CYC = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               trig_in,
   input  logic               update_in,
   input  logic [NCH-1:0]     ch_mask,
   input  logic               clr_err,
   input  logic               adc_done,
   input  logic [DW-1:0]      adc_data,
   output logic               adc_start,
   output logic [CHW-1:0]     adc_ch,
   output logic [NCH*DW-1:0]  res_bus,
   output logic               res_valid,
   output logic               busy,
   output logic               overrun,
   output logic               timeout
);

   localparam int CW = $clog2(TO_CYC + 1);

   typedef enum logic [2:0] {
      IDLE, SEL, START, WAIT, NEXT, DONE
   } state_t;

   state_t state, state_n;

   logic           trig_q;
   logic           trig_edge;
   logic [NCH-1:0] mask_q;
   logic [NCH-1:0] mask_nxt;
   logic [CW-1:0]  cnt;
   logic [DW-1:0]  shadow [NCH];
   logic [CHW-1:0] low;

   logic ld_mask;
   logic pub;
   logic ovr_set;
   logic to_set;
   logic wr_sh;

   assign trig_edge = trig_in & ~trig_q;
   // x & (x-1) drops the lowest set bit
   assign mask_nxt  = mask_q & (mask_q - NCH'(1));
   assign adc_start = (state == START);
   assign busy      = (state != IDLE);

   always_comb begin
      low = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (mask_q[k]) low = CHW'(k);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      ld_mask = 1'b0;
      pub     = 1'b0;
      ovr_set = 1'b0;
      to_set  = 1'b0;
      wr_sh   = 1'b0;
      unique case (state)
         IDLE: begin
            if (trig_edge && (|ch_mask)) begin
               ld_mask = 1'b1;
               state_n = SEL;
            end
         end
         SEL: begin
            ovr_set = trig_edge;
            state_n = START;
         end
         START: begin
            ovr_set = trig_edge;
            state_n = WAIT;
         end
         WAIT: begin
            ovr_set = trig_edge;
            if (adc_done) begin
               wr_sh   = 1'b1;
               state_n = NEXT;
            end else if (cnt == CW'(TO_CYC - 1)) begin
               to_set  = 1'b1;
               state_n = NEXT;
            end
         end
         NEXT: begin
            ovr_set = trig_edge;
            state_n = (|mask_q) ? SEL : DONE;
         end
         DONE: begin
            if (update_in) begin
               pub     = 1'b1;
               state_n = IDLE;
               // a trigger coinciding with publish starts a fresh sequence
               if (trig_edge && (|ch_mask)) begin
                  ld_mask = 1'b1;
                  state_n = SEL;
               end
            end else if (trig_edge) begin
               ovr_set = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         trig_q    <= 1'b0;
         mask_q    <= '0;
         cnt       <= '0;
         adc_ch    <= '0;
         res_bus   <= '0;
         res_valid <= 1'b0;
         overrun   <= 1'b0;
         timeout   <= 1'b0;
         for (int k = 0; k < NCH; k++) shadow[k] <= '0;
      end else begin
         trig_q    <= trig_in;
         res_valid <= pub;
         if (ld_mask) begin
            mask_q <= ch_mask;
         end else if (state == SEL) begin
            mask_q <= mask_nxt;
            adc_ch <= low;
         end
         if (state == START)     cnt <= '0;
         else if (state == WAIT) cnt <= cnt + CW'(1);
         if (wr_sh) shadow[adc_ch] <= adc_data;
         if (pub) begin
            for (int k = 0; k < NCH; k++) res_bus[k*DW +: DW] <= shadow[k];
         end
         if (ovr_set)      overrun <= 1'b1;
         else if (clr_err) overrun <= 1'b0;
         if (to_set)       timeout <= 1'b1;
         else if (clr_err) timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adc_seq_sched.sv
// Directed bench for adc_seq_sched: ADC responder model plus scoreboards
// for conversion starts and published result words.
module tb_adc_seq_sched;

   localparam int NCH = 4;
   localparam int CHW = 2;
   localparam int DW  = 12;
   localparam int TO  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              trig_in = 1'b0;
   logic              update_in = 1'b0;
   logic [NCH-1:0]    ch_mask = '0;
   logic              clr_err = 1'b0;
   logic              adc_done = 1'b0;
   logic [DW-1:0]     adc_data = '0;
   logic              adc_start;
   logic [CHW-1:0]    adc_ch;
   logic [NCH*DW-1:0] res_bus;
   logic              res_valid;
   logic              busy;
   logic              overrun;
   logic              timeout;

   adc_seq_sched #(
      .NCH(NCH), .CHW(CHW), .DW(DW), .TO_CYC(TO)
   ) dut (
      .clk(clk), .rst(rst), .trig_in(trig_in), .update_in(update_in),
      .ch_mask(ch_mask), .clr_err(clr_err), .adc_done(adc_done),
      .adc_data(adc_data), .adc_start(adc_start), .adc_ch(adc_ch),
      .res_bus(res_bus), .res_valid(res_valid), .busy(busy),
      .overrun(overrun), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int c;
      int ch;
   } st_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rvn = 0;
   int dcnt = 0;
   int dch = 0;
   int lat = 5;
   int e;
   int r0;
   bit mdl_on = 1'b0;
   logic [DW-1:0] dbase = '0;
   logic [DW-1:0] expb [NCH];
   st_t sq[$];
   logic [NCH*DW-1:0] sb[$];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [NCH*DW-1:0] pack_exp();
      logic [NCH*DW-1:0] r;
      r = '0;
      for (int k = 0; k < NCH; k++) r[k*DW +: DW] = expb[k];
      return r;
   endfunction

   task automatic step();
      st_t s;
      @(posedge clk);
      #1;
      cyc++;
      if (adc_start) begin
         if (sq.size() == 0) begin
            chk("start_unexpected", adc_start, 0);
         end else begin
            s = sq.pop_front();
            chk("start_cycle", cyc, s.c);
            chk("start_ch", adc_ch, s.ch);
         end
      end
      if (res_valid) begin
         rvn++;
         if (sb.size() == 0) chk("rv_unexpected", res_valid, 0);
         else                chk("res_bus", res_bus, sb.pop_front());
      end
      adc_done = 1'b0;
      if (dcnt > 0) begin
         dcnt--;
         if (dcnt == 0) begin
            adc_done = 1'b1;
            adc_data = dbase + DW'(dch);
         end
      end
      if (adc_start && mdl_on) begin
         dcnt = lat;
         dch  = int'(adc_ch);
      end
   endtask

   task automatic goto(input int c);
      while (cyc < c) step();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      for (int k = 0; k < NCH; k++) expb[k] = '0;

      // reset
      rst = 1'b0;
      run(3);
      chk("rst_busy", busy, 0);
      chk("rst_start", adc_start, 0);
      chk("rst_ch", adc_ch, 0);
      chk("rst_bus", res_bus, 0);
      chk("rst_rv", res_valid, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_to", timeout, 0);
      rst = 1'b1;
      step();

      // 1: mask 1011, normal sequence
      mdl_on = 1'b1; lat = 5; dbase = 12'h100;
      ch_mask = 4'b1011; trig_in = 1'b1; e = cyc;
      sq.push_back('{c: e + 2, ch: 0});
      sq.push_back('{c: e + 10, ch: 1});
      sq.push_back('{c: e + 18, ch: 3});
      step();
      trig_in = 1'b0;
      goto(e + 30);
      expb[0] = 12'h100; expb[1] = 12'h101; expb[3] = 12'h103;
      sb.push_back(pack_exp());
      r0 = rvn;
      update_in = 1'b1;
      step();
      update_in = 1'b0;
      run(3);
      chk("t1_rv_once", rvn - r0, 1);
      chk("t1_starts_left", sq.size(), 0);
      chk("t1_idle", busy, 0);

      // 2: timeout on ch0
      mdl_on = 1'b0;
      ch_mask = 4'b0001; trig_in = 1'b1; e = cyc;
      sq.push_back('{c: e + 2, ch: 0});
      step();
      trig_in = 1'b0;
      goto(e + 10);
      chk("t2_to_early", timeout, 0);
      step();
      chk("t2_to_set", timeout, 1);
      goto(e + 14);
      chk("t2_busy_done", busy, 1);
      sb.push_back(pack_exp());
      r0 = rvn;
      update_in = 1'b1;
      step();
      update_in = 1'b0;
      step();
      chk("t2_rv", rvn - r0, 1);
      chk("t2_to_sticky", timeout, 1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("t2_to_clr", timeout, 0);
      chk("t2_idle", busy, 0);

      // 3: overrun in WAIT and in DONE
      mdl_on = 1'b1; dbase = 12'h200;
      ch_mask = 4'b0011; trig_in = 1'b1; e = cyc;
      sq.push_back('{c: e + 2, ch: 0});
      sq.push_back('{c: e + 10, ch: 1});
      step();
      trig_in = 1'b0;
      goto(e + 4);
      chk("t3_ovr_pre", overrun, 0);
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
      chk("t3_ovr_wait", overrun, 1);
      goto(e + 18);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("t3_ovr_clr", overrun, 0);
      goto(e + 20);
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
      chk("t3_ovr_done", overrun, 1);
      chk("t3_busy_done", busy, 1);
      expb[0] = 12'h200; expb[1] = 12'h201;
      sb.push_back(pack_exp());
      r0 = rvn;
      goto(e + 23);
      update_in = 1'b1;
      step();
      update_in = 1'b0;
      run(3);
      chk("t3_rv_once", rvn - r0, 1);
      chk("t3_idle", busy, 0);
      chk("t3_starts_left", sq.size(), 0);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("t3_ovr_clr2", overrun, 0);

      // 4: update and trigger edge together in DONE
      dbase = 12'h300;
      ch_mask = 4'b0001; trig_in = 1'b1; e = cyc;
      sq.push_back('{c: e + 2, ch: 0});
      step();
      trig_in = 1'b0;
      goto(e + 12);
      expb[0] = 12'h300;
      sb.push_back(pack_exp());
      r0 = rvn;
      update_in = 1'b1; trig_in = 1'b1; ch_mask = 4'b0010;
      sq.push_back('{c: e + 14, ch: 1});
      step();
      update_in = 1'b0; trig_in = 1'b0;
      chk("t4_rv", res_valid, 1);
      goto(e + 14);
      chk("t4_restart", adc_start, 1);
      chk("t4_ovr", overrun, 0);
      goto(e + 24);
      expb[1] = 12'h301;
      sb.push_back(pack_exp());
      update_in = 1'b1;
      step();
      update_in = 1'b0;
      run(2);
      chk("t4_rv_two", rvn - r0, 2);
      chk("t4_ovr_end", overrun, 0);
      chk("t4_idle", busy, 0);

      // 6: empty mask ignored; done during START ignored
      mdl_on = 1'b0;
      ch_mask = 4'b0000; trig_in = 1'b1;
      step();
      trig_in = 1'b0;
      run(4);
      chk("t6_mask0_busy", busy, 0);
      chk("t6_mask0_ovr", overrun, 0);
      ch_mask = 4'b0100; trig_in = 1'b1; e = cyc;
      sq.push_back('{c: e + 2, ch: 2});
      step();
      trig_in = 1'b0;
      goto(e + 2);
      adc_done = 1'b1; adc_data = 12'hAAA;
      step();
      goto(e + 5);
      chk("t6_still_wait", busy, 1);
      goto(e + 6);
      adc_done = 1'b1; adc_data = 12'h555;
      step();
      goto(e + 10);
      expb[2] = 12'h555;
      sb.push_back(pack_exp());
      update_in = 1'b1;
      step();
      update_in = 1'b0;
      run(2);
      chk("t6_no_to", timeout, 0);
      chk("t6_idle", busy, 0);
      chk("t6_sb_empty", sb.size(), 0);

      // 5: reset during WAIT of channel 1
      mdl_on = 1'b1; dbase = 12'h400;
      ch_mask = 4'b0011; trig_in = 1'b1; e = cyc;
      sq.push_back('{c: e + 2, ch: 0});
      sq.push_back('{c: e + 10, ch: 1});
      step();
      trig_in = 1'b0;
      goto(e + 4);
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
      goto(e + 12);
      chk("t5_ovr_pre", overrun, 1);
      chk("t5_busy_pre", busy, 1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("t5_busy", busy, 0);
      chk("t5_start", adc_start, 0);
      chk("t5_ch", adc_ch, 0);
      chk("t5_bus", res_bus, 0);
      chk("t5_ovr", overrun, 0);
      chk("t5_to", timeout, 0);
      r0 = rvn;
      update_in = 1'b1;
      run(6);
      update_in = 1'b0;
      chk("t5_no_rv", rvn - r0, 0);
      chk("t5_bus_late", res_bus, 0);
      chk("t5_idle", busy, 0);
      chk("t5_starts_left", sq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
